// File: rtl/pipe_writeback.sv
// Result writeback stage: queues pipe results behind the external (load) writer
// and retires them in order into a 32-entry register file with a busy scoreboard.
module pipe_writeback #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic                     res_valid,
  input  logic [WIDTH-1:0]         res_data,
  input  logic [4:0]               res_rd,
  input  logic                     ext_wr_en,
  input  logic [4:0]               ext_wr_rd,
  input  logic [WIDTH-1:0]         ext_wr_data,
  input  logic [4:0]               rd_a_addr,
  input  logic [4:0]               rd_b_addr,
  output logic [WIDTH-1:0]         rd_a_data,
  output logic [WIDTH-1:0]         rd_b_data,
  output logic                     rd_a_busy,
  output logic                     rd_b_busy,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_rf     [32];
  logic [31:0]      r_busy;
  logic [4:0]       r_q_rd   [DEPTH];
  logic [WIDTH-1:0] r_q_data [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;
  logic             r_ovf;

  logic             w_res_ok;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_ext;
  logic             w_wr_en;
  logic [4:0]       w_wr_addr;
  logic [WIDTH-1:0] w_wr_data;
  logic [4:0]       w_head_rd;
  logic [31:0]      w_busy_nxt;

  function automatic logic [WIDTH-1:0] read_port(
    input logic [4:0]       addr,
    input logic             wr_en,
    input logic [4:0]       wr_addr,
    input logic [WIDTH-1:0] wr_data,
    input logic [WIDTH-1:0] rf_val
  );
    if (addr == 5'd0)
      return '0;
    else if (wr_en && (wr_addr == addr))
      return wr_data;
    else
      return rf_val;
  endfunction

  assign w_res_ok  = res_valid && (res_rd != 5'd0);
  assign w_full    = (r_count == L_FULL);
  // The external writer owns the single write port; the FIFO drains only when it is idle.
  assign w_pop     = (r_count != '0) && !ext_wr_en;
  assign w_push    = w_res_ok && (!w_full || w_pop);
  assign w_ext     = ext_wr_en && (ext_wr_rd != 5'd0);
  assign w_head_rd = r_q_rd[r_head];

  assign w_wr_en   = w_ext || (w_pop && (w_head_rd != 5'd0));
  assign w_wr_addr = w_ext ? ext_wr_rd : w_head_rd;
  assign w_wr_data = w_ext ? ext_wr_data : r_q_data[r_head];

  // Clear from the retiring result first so a same-edge issue to that register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop)
      w_busy_nxt[w_head_rd] = 1'b0;
    if (issue_valid)
      w_busy_nxt[issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        r_rf[i] <= '0;
      r_busy  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr_en)
        r_rf[w_wr_addr] <= w_wr_data;
      r_busy <= w_busy_nxt;
      if (w_push)
        r_tail <= r_tail + 1'b1;
      if (w_pop)
        r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_res_ok && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  // Queue storage carries data only; occupancy is tracked by the control registers above.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_tail]   <= res_rd;
      r_q_data[r_tail] <= res_data;
    end
  end

  assign rd_a_data  = read_port(rd_a_addr, w_wr_en, w_wr_addr, w_wr_data, r_rf[rd_a_addr]);
  assign rd_b_data  = read_port(rd_b_addr, w_wr_en, w_wr_addr, w_wr_data, r_rf[rd_b_addr]);
  assign rd_a_busy  = r_busy[rd_a_addr];
  assign rd_b_busy  = r_busy[rd_b_addr];
  assign fifo_full  = w_full;
  assign fifo_count = r_count;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_pipe_writeback.sv
// Bench for pipe_writeback: directed scenarios plus randomized traffic against a
// queue-based reference model of the writeback rules.
module tb_pipe_writeback;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic              clk;
  logic              rst;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic              res_valid;
  logic [WIDTH-1:0]  res_data;
  logic [4:0]        res_rd;
  logic              ext_wr_en;
  logic [4:0]        ext_wr_rd;
  logic [WIDTH-1:0]  ext_wr_data;
  logic [4:0]        rd_a_addr;
  logic [4:0]        rd_b_addr;
  logic [WIDTH-1:0]  rd_a_data;
  logic [WIDTH-1:0]  rd_b_data;
  logic              rd_a_busy;
  logic              rd_b_busy;
  logic              fifo_full;
  logic [2:0]        fifo_count;
  logic              ovf;

  int errors = 0;
  int checks = 0;

  pipe_writeback #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
    .ext_wr_en(ext_wr_en), .ext_wr_rd(ext_wr_rd), .ext_wr_data(ext_wr_data),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .rd_a_busy(rd_a_busy), .rd_b_busy(rd_b_busy),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register file, busy set, and a queue of pending results.
  typedef struct packed {
    logic [4:0]       rd;
    logic [WIDTH-1:0] data;
  } ent_t;

  logic [WIDTH-1:0] m_rf [32];
  bit   [31:0]      m_busy;
  ent_t             m_q[$];
  bit               m_ovf;

  function automatic void model_tick();
    ent_t h;
    bit   pop;
    if (rst) begin
      foreach (m_rf[i]) m_rf[i] = '0;
      m_busy = '0;
      m_q.delete();
      m_ovf = 1'b0;
      return;
    end
    pop = (m_q.size() > 0) && !ext_wr_en;
    if (ext_wr_en && ext_wr_rd != 0)
      m_rf[ext_wr_rd] = ext_wr_data;
    if (pop) begin
      h = m_q.pop_front();
      m_rf[h.rd] = h.data;
      m_busy[h.rd] = 1'b0;
    end
    if (res_valid && res_rd != 0) begin
      if (m_q.size() < DEPTH) m_q.push_back('{rd: res_rd, data: res_data});
      else m_ovf = 1'b1;
    end
    if (issue_valid && issue_rd != 0)
      m_busy[issue_rd] = 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] exp_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (ext_wr_en && ext_wr_rd == a) return ext_wr_data;
    if (!ext_wr_en && m_q.size() > 0 && m_q[0].rd == a) return m_q[0].data;
    return m_rf[a];
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    res_valid   = 1'b0;
    ext_wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    issue_rd = '0; res_rd = '0; res_data = '0; ext_wr_rd = '0; ext_wr_data = '0;
    rd_a_addr = '0; rd_b_addr = '0;
    cycle(); cycle();
    rst = 1'b0;
    rd_a_addr = 5'd5;
    #1;
    checks++; if (rd_a_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", rd_a_data); end
    checks++; if (rd_a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rd_a_busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_bypass();
    issue_valid = 1'b1; issue_rd = 5'd3; rd_a_addr = 5'd3;
    cycle();
    idle(); #1;
    checks++; if (rd_a_busy !== 1'b1) begin errors++; $display("FAIL byp_busy_set: got %b want 1", rd_a_busy); end
    cycle();
    res_valid = 1'b1; res_rd = 5'd3; res_data = 32'h0000_1234; #1;
    checks++; if (rd_a_data !== 32'd0) begin errors++; $display("FAIL byp_no_fifo_bypass: got %h want 0", rd_a_data); end
    cycle();
    idle(); #1;
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL byp_count: got %0d want 1", fifo_count); end
    checks++; if (rd_a_data !== 32'h1234) begin errors++; $display("FAIL byp_pop_bypass: got %h want 1234", rd_a_data); end
    checks++; if (rd_a_busy !== 1'b1) begin errors++; $display("FAIL byp_busy_held: got %b want 1", rd_a_busy); end
    cycle();
    checks++; if (rd_a_busy !== 1'b0) begin errors++; $display("FAIL byp_busy_clr: got %b want 0", rd_a_busy); end
    checks++; if (rd_a_data !== 32'h1234) begin errors++; $display("FAIL byp_written: got %h want 1234", rd_a_data); end
  endtask

  task automatic test_overflow();
    ext_wr_en = 1'b1; ext_wr_rd = 5'd20; ext_wr_data = 32'hDEAD_0020; rd_b_addr = 5'd20;
    for (int k = 0; k < 5; k++) begin
      res_valid = 1'b1;
      res_rd    = (k < 4) ? 5'(k + 1) : 5'd6;
      res_data  = (k < 4) ? 32'(k + 1) : 32'd6;
      #1;
      if (k == 0) begin
        checks++; if (rd_b_data !== 32'hDEAD_0020) begin errors++; $display("FAIL ovf_ext_bypass: got %h want dead0020", rd_b_data); end
      end
      cycle();
      if (k == 3) begin
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", fifo_full); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", ovf); end
      end
    end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
    idle();
    for (int k = 0; k < 4; k++) begin
      rd_a_addr = 5'(k + 1); #1;
      checks++; if (rd_a_data !== 32'(k + 1)) begin errors++; $display("FAIL ovf_order%0d: got %h want %h", k, rd_a_data, k + 1); end
      checks++; if (fifo_count !== 3'(4 - k)) begin errors++; $display("FAIL ovf_drain%0d: got %0d want %0d", k, fifo_count, 4 - k); end
      cycle();
    end
    rd_a_addr = 5'd6; rd_b_addr = 5'd2; #1;
    checks++; if (rd_a_data !== 32'd0) begin errors++; $display("FAIL ovf_dropped: got %h want 0", rd_a_data); end
    checks++; if (rd_b_data !== 32'd2) begin errors++; $display("FAIL ovf_r2: got %h want 2", rd_b_data); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_full_push_pop();
    rst = 1'b1; idle(); cycle(); rst = 1'b0;
    ext_wr_en = 1'b1; ext_wr_rd = 5'd21; ext_wr_data = 32'h5;
    for (int k = 0; k < 4; k++) begin
      res_valid = 1'b1; res_rd = 5'(10 + k); res_data = 32'hA0 + 32'(k);
      cycle();
    end
    ext_wr_en = 1'b0; res_valid = 1'b1; res_rd = 5'd14; res_data = 32'hA4; rd_a_addr = 5'd10; #1;
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b want 1", fifo_full); end
    checks++; if (rd_a_data !== 32'hA0) begin errors++; $display("FAIL fpp_head: got %h want a0", rd_a_data); end
    cycle();
    idle(); #1;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fpp_count: got %0d want 4", fifo_count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b want 0", ovf); end
    for (int k = 0; k < 4; k++) begin
      rd_a_addr = 5'(11 + k); #1;
      checks++; if (rd_a_data !== 32'hA1 + 32'(k)) begin errors++; $display("FAIL fpp_order%0d: got %h want %h", k, rd_a_data, 32'hA1 + 32'(k)); end
      cycle();
    end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL fpp_empty: got %0d want 0", fifo_count); end
  endtask

  task automatic test_busy_rules();
    issue_valid = 1'b1; issue_rd = 5'd7; cycle();
    idle(); ext_wr_en = 1'b1; ext_wr_rd = 5'd21; ext_wr_data = 32'h5;
    res_valid = 1'b1; res_rd = 5'd7; res_data = 32'h77; cycle();
    idle(); issue_valid = 1'b1; issue_rd = 5'd7; rd_a_addr = 5'd7; #1;
    checks++; if (rd_a_data !== 32'h77) begin errors++; $display("FAIL bsy_pop_bypass: got %h want 77", rd_a_data); end
    cycle();
    idle(); #1;
    checks++; if (rd_a_busy !== 1'b1) begin errors++; $display("FAIL bsy_set_wins: got %b want 1", rd_a_busy); end
    checks++; if (rd_a_data !== 32'h77) begin errors++; $display("FAIL bsy_r7: got %h want 77", rd_a_data); end
    issue_valid = 1'b1; issue_rd = 5'd9; cycle();
    idle(); ext_wr_en = 1'b1; ext_wr_rd = 5'd9; ext_wr_data = 32'h99; rd_b_addr = 5'd9; #1;
    checks++; if (rd_b_data !== 32'h99) begin errors++; $display("FAIL bsy_ext_bypass: got %h want 99", rd_b_data); end
    cycle();
    idle(); #1;
    checks++; if (rd_b_data !== 32'h99) begin errors++; $display("FAIL bsy_ext_data: got %h want 99", rd_b_data); end
    checks++; if (rd_b_busy !== 1'b1) begin errors++; $display("FAIL bsy_ext_keeps: got %b want 1", rd_b_busy); end
    ext_wr_en = 1'b1; ext_wr_rd = 5'd0; ext_wr_data = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    res_valid = 1'b1; res_rd = 5'd0; res_data = 32'h123;
    rd_a_addr = 5'd0; rd_b_addr = 5'd0; #1;
    checks++; if (rd_a_data !== 32'd0) begin errors++; $display("FAIL r0_bypass: got %h want 0", rd_a_data); end
    cycle();
    idle(); #1;
    checks++; if (rd_b_data !== 32'd0) begin errors++; $display("FAIL r0_data: got %h want 0", rd_b_data); end
    checks++; if (rd_b_busy !== 1'b0) begin errors++; $display("FAIL r0_busy: got %b want 0", rd_b_busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL r0_no_push: got %0d want 0", fifo_count); end
  endtask

  task automatic test_reset_mid();
    ext_wr_en = 1'b1; ext_wr_rd = 5'd22; ext_wr_data = 32'h1;
    for (int k = 0; k < 3; k++) begin
      res_valid = 1'b1; res_rd = 5'(1 + k); res_data = 32'hB0 + 32'(k);
      issue_valid = 1'b1; issue_rd = 5'(15 + k);
      cycle();
    end
    idle(); ext_wr_en = 1'b1; rd_a_addr = 5'd15; #1;
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL rm_pre_count: got %0d want 3", fifo_count); end
    checks++; if (rd_a_busy !== 1'b1) begin errors++; $display("FAIL rm_pre_busy: got %b want 1", rd_a_busy); end
    idle(); rst = 1'b1; cycle();
    rst = 1'b0; rd_b_addr = 5'd7; #1;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rm_count: got %0d want 0", fifo_count); end
    checks++; if (rd_a_busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", rd_a_busy); end
    checks++; if (rd_b_data !== 32'd0) begin errors++; $display("FAIL rm_reg: got %h want 0", rd_b_data); end
    cycle();
    rd_a_addr = 5'd1; rd_b_addr = 5'd9; #1;
    checks++; if (rd_a_data !== 32'd0) begin errors++; $display("FAIL rm_discard: got %h want 0", rd_a_data); end
    checks++; if (rd_b_data !== 32'd0) begin errors++; $display("FAIL rm_r9: got %h want 0", rd_b_data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      issue_valid = $urandom_range(0, 1);
      issue_rd    = 5'($urandom);
      res_valid   = ($urandom_range(0, 9) < 6);
      res_rd      = 5'($urandom_range(0, 7));
      res_data    = $urandom;
      ext_wr_en   = ($urandom_range(0, 9) < 4);
      ext_wr_rd   = 5'($urandom_range(0, 7));
      ext_wr_data = $urandom;
      rd_a_addr   = 5'($urandom_range(0, 7));
      rd_b_addr   = 5'($urandom_range(0, 7));
      #1;
      checks++; if (rd_a_data !== exp_read(rd_a_addr)) begin errors++; $display("FAIL rnd_a_data@%0d: got %h want %h", n, rd_a_data, exp_read(rd_a_addr)); end
      checks++; if (rd_b_data !== exp_read(rd_b_addr)) begin errors++; $display("FAIL rnd_b_data@%0d: got %h want %h", n, rd_b_data, exp_read(rd_b_addr)); end
      checks++; if (rd_a_busy !== m_busy[rd_a_addr]) begin errors++; $display("FAIL rnd_a_busy@%0d: got %b want %b", n, rd_a_busy, m_busy[rd_a_addr]); end
      checks++; if (rd_b_busy !== m_busy[rd_b_addr]) begin errors++; $display("FAIL rnd_b_busy@%0d: got %b want %b", n, rd_b_busy, m_busy[rd_b_addr]); end
      checks++; if (fifo_count !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, fifo_count, m_q.size()); end
      checks++; if (fifo_full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full@%0d: got %b want %b", n, fifo_full, m_q.size() == DEPTH); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf@%0d: got %b want %b", n, ovf, m_ovf); end
      cycle();
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_overflow();
    test_full_push_pop();
    test_busy_rules();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
